aes_core_arbiter: RTL and testbench

- Shares one AES core between NUM_REQ requesters, e.g. the XEX tweak path and data path, or several XEX channels.
- Arbitrates round-robin and grants one requester at a time.
- Issues a single-cycle d_valid strobe with the requester's enc/dec mode to the core, then holds the grant until the core reports aes_rdy.
- Sits between the XEX-level controllers and the AES core. Data/key muxing is external and steered by gnt_idx.

---
 rtl/aes_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 32 +++
 rtl/aes_core_arbiter.sv | 129 ++++++++++++
 tb/tb_aes_core_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES core arbiter: FSM state encoding,
// enc/dec mode values and the default WAIT watchdog limit.
package aes_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        REL  = 2'd3
    } arb_state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYC = 64;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: returns the first set request at or
// after rr_ptr, scanning circularly.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    rr_ptr,
    output logic               found,
    output logic [IDXW-1:0]    idx
);

    int pos;

    // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pos = int'(rr_ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req[IDXW'(pos)]) begin
                found = 1'b1;
                idx   = IDXW'(pos);
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int IDXW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_mode,
    input  logic               aes_bz,
    input  logic               aes_rdy,
    output logic               aes_d_valid,
    output logic               aes_enc_dec,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDXW-1:0]    gnt_idx,
    output logic [NUM_REQ-1:0] done,
    output logic               err,
    output logic               arb_bz
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic            timeout_hit;
    logic            take_grant;
    logic            end_grant;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC) + 1;

    logic [CNTW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == SEND) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNTW'(1);
        end
    end

    assign timeout_hit = (state == WAIT) && (wait_cnt == CNTW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // aes_rdy is checked before the watchdog so a same-cycle result still completes.
    always_comb begin
        state_nxt   = state;
        aes_d_valid = 1'b0;
        done        = '0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found && !aes_bz) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                aes_d_valid = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (aes_rdy) begin
                    done      = gnt;
                    state_nxt = REL;
                end else if (timeout_hit) begin
                    err       = 1'b1;
                    state_nxt = REL;
                end
            end
            REL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign take_grant = (state == IDLE) && (state_nxt == SEND);
    assign end_grant  = (state == WAIT) && (state_nxt == REL);
    assign arb_bz     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant registers load on IDLE->SEND; rr_ptr moves past the finished requester on WAIT->REL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt         <= '0;
            gnt_idx     <= '0;
            aes_enc_dec <= MODE_ENC;
            rr_ptr      <= '0;
        end else if (take_grant) begin
            gnt         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gnt_idx     <= pick_idx;
            aes_enc_dec <= req_mode[pick_idx];
        end else if (end_grant) begin
            gnt         <= '0;
            gnt_idx     <= '0;
            aes_enc_dec <= MODE_ENC;
            rr_ptr      <= (gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDXW'(1);
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter (NUM_REQ=2); the watchdog section
// follows AES_ARB_TIMEOUT_EN like the design.
module tb_aes_core_arbiter;
    import aes_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int IDXW    = 1;
    localparam int TCYC    = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_mode;
    logic               aes_bz;
    logic               aes_rdy;
    logic               aes_d_valid;
    logic               aes_enc_dec;
    logic [NUM_REQ-1:0] gnt;
    logic [IDXW-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] done;
    logic               err;
    logic               arb_bz;

    int n_checks = 0;
    int n_fails  = 0;

    aes_core_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_mode    (req_mode),
        .aes_bz      (aes_bz),
        .aes_rdy     (aes_rdy),
        .aes_d_valid (aes_d_valid),
        .aes_enc_dec (aes_enc_dec),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .done        (done),
        .err         (err),
        .arb_bz      (arb_bz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_idx"}, 32'(gnt_idx), 32'd0);
        check({tag, "_dv"}, 32'(aes_d_valid), 32'd0);
        check({tag, "_mode"}, 32'(aes_enc_dec), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_bz"}, 32'(arb_bz), 32'd0);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        req      = '0;
        req_mode = '0;
        aes_bz   = 1'b0;
        aes_rdy  = 1'b0;
        #2;
        check_all_zero("reset");
        step();
        rst = 1'b0;
    endtask

    // Guards against a hang; a FAIL line precedes the fatal stop.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        // Single request: requester 0, decrypt, result 12 cycles after strobe.
        apply_reset();
        req      = 2'b01;
        req_mode = 2'b01;
        #1;
        check("t1_idle_dv", 32'(aes_d_valid), 32'd0);
        step();
        check("t1_send_dv", 32'(aes_d_valid), 32'd1);
        check("t1_send_mode", 32'(aes_enc_dec), 32'(MODE_DEC));
        check("t1_send_gnt", 32'(gnt), 32'b01);
        check("t1_send_idx", 32'(gnt_idx), 32'd0);
        check("t1_send_bz", 32'(arb_bz), 32'd1);
        for (int k = 1; k < 12; k++) begin
            step();
            check("t1_wait_dv", 32'(aes_d_valid), 32'd0);
            check("t1_wait_done", 32'(done), 32'd0);
            check("t1_wait_gnt", 32'(gnt), 32'b01);
        end
        step();
        aes_rdy = 1'b1;
        #1;
        check("t1_done", 32'(done), 32'b01);
        check("t1_done_err", 32'(err), 32'd0);
        step();
        aes_rdy = 1'b0;
        req     = '0;
        #1;
        check("t1_rel_gnt", 32'(gnt), 32'd0);
        check("t1_rel_done", 32'(done), 32'd0);
        check("t1_rel_bz", 32'(arb_bz), 32'd1);
        step();
        check("t1_idle_bz", 32'(arb_bz), 32'd0);
        aes_rdy = 1'b1;
        #1;
        check("t1_idle_rdy_done", 32'(done), 32'd0);
        step();
        aes_rdy = 1'b0;
        check("t1_idle_rdy_bz", 32'(arb_bz), 32'd0);

        // Round-robin: both requesting, core answers 3 cycles after the strobe.
        apply_reset();
        req      = 2'b11;
        req_mode = 2'b00;
        for (int g = 0; g < 4; g++) begin
            step();
            check("rr_idx", 32'(gnt_idx), 32'(g % 2));
            check("rr_gnt", 32'(gnt), 32'd1 << (g % 2));
            check("rr_dv", 32'(aes_d_valid), 32'd1);
            step();
            step();
            step();
            aes_rdy = 1'b1;
            #1;
            check("rr_done", 32'(done), 32'd1 << (g % 2));
            step();
            aes_rdy = 1'b0;
            check("rr_rel_gnt", 32'(gnt), 32'd0);
            step();
        end
        req = '0;

        // Busy core blocks the grant until aes_bz falls.
        aes_bz = 1'b1;
        req    = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("busy_dv", 32'(aes_d_valid), 32'd0);
            check("busy_arb_bz", 32'(arb_bz), 32'd0);
            step();
        end
        aes_bz = 1'b0;
        #1;
        check("busy_fall_dv", 32'(aes_d_valid), 32'd0);
        step();
        check("busy_send_dv", 32'(aes_d_valid), 32'd1);
        check("busy_send_gnt", 32'(gnt), 32'b10);
        check("busy_send_idx", 32'(gnt_idx), 32'd1);
        step();
        aes_rdy = 1'b1;
        #1;
        check("busy_done", 32'(done), 32'b10);
        step();
        aes_rdy = 1'b0;
        req     = '0;
        step();

        // Dropped request and mode change after grant; aes_rdy in SEND ignored.
        req      = 2'b01;
        req_mode = 2'b00;
        step();
        check("drop_send_mode", 32'(aes_enc_dec), 32'(MODE_ENC));
        check("drop_send_gnt", 32'(gnt), 32'b01);
        aes_rdy = 1'b1;
        #1;
        check("drop_send_rdy_done", 32'(done), 32'd0);
        step();
        aes_rdy  = 1'b0;
        req      = '0;
        req_mode = 2'b11;
        #1;
        check("drop_wait_gnt", 32'(gnt), 32'b01);
        check("drop_wait_mode", 32'(aes_enc_dec), 32'(MODE_ENC));
        step();
        step();
        aes_rdy = 1'b1;
        #1;
        check("drop_done", 32'(done), 32'b01);
        check("drop_done_mode", 32'(aes_enc_dec), 32'(MODE_ENC));
        step();
        aes_rdy  = 1'b0;
        req_mode = 2'b00;
        step();
        check("drop_idle_bz", 32'(arb_bz), 32'd0);

        // Mid-operation reset: rr_ptr is 1 here, so the grant goes to requester 1.
        req = 2'b11;
        step();
        check("mrst_pre_idx", 32'(gnt_idx), 32'd1);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mrst");
        req = '0;
        step();
        aes_rdy = 1'b1;
        #1;
        check("mrst_rdy_done", 32'(done), 32'd0);
        step();
        aes_rdy = 1'b0;
        rst     = 1'b0;
        req     = 2'b11;
        step();
        check("mrst_post_idx", 32'(gnt_idx), 32'd0);
        check("mrst_post_gnt", 32'(gnt), 32'b01);
        step();
        aes_rdy = 1'b1;
        #1;
        check("mrst_post_done", 32'(done), 32'b01);
        step();
        aes_rdy = 1'b0;
        req     = '0;
        step();

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog expiry 8 cycles after SEND, then pointer must have advanced.
        apply_reset();
        req = 2'b01;
        step();
        for (int k = 1; k < TCYC; k++) begin
            step();
            check("to_wait_err", 32'(err), 32'd0);
            check("to_wait_done", 32'(done), 32'd0);
        end
        step();
        check("to_err", 32'(err), 32'd1);
        check("to_err_done", 32'(done), 32'd0);
        check("to_err_gnt", 32'(gnt), 32'b01);
        req = '0;
        step();
        check("to_rel_err", 32'(err), 32'd0);
        check("to_rel_gnt", 32'(gnt), 32'd0);
        step();
        req = 2'b11;
        step();
        check("to_next_idx", 32'(gnt_idx), 32'd1);
        // aes_rdy in the expiry cycle wins over the watchdog.
        for (int k = 1; k < TCYC; k++) begin
            step();
        end
        step();
        aes_rdy = 1'b1;
        #1;
        check("to_tie_done", 32'(done), 32'b10);
        check("to_tie_err", 32'(err), 32'd0);
        step();
        aes_rdy = 1'b0;
        req     = '0;
        step();
`else
        // Without the watchdog a stalled core keeps the grant indefinitely.
        req = 2'b01;
        step();
        for (int k = 0; k < 3 * TCYC; k++) begin
            step();
            check("nowd_err", 32'(err), 32'd0);
        end
        check("nowd_gnt", 32'(gnt), 32'b01);
        check("nowd_bz", 32'(arb_bz), 32'd1);
        aes_rdy = 1'b1;
        #1;
        check("nowd_done", 32'(done), 32'b01);
        step();
        aes_rdy = 1'b0;
        req     = '0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
